// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/stack-side signal bundle for pc_sequencer
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 13
) ();
    logic                step;
    logic [2:0]          op;
    logic [10:0]         lit;
    logic [4:0]          pclath;
    logic [7:0]          pcl_data;
    logic                int_req;
    logic [PC_WIDTH-1:0] stk_top;
    logic [PC_WIDTH-1:0] pc;
    logic                flush;
    logic                stk_push;
    logic                stk_pop;
    logic [PC_WIDTH-1:0] stk_in;
    logic                int_ack;
    logic                gie_set;
    logic                stk_overflow;
    logic                stk_underflow;

    modport master (
        input  step, op, lit, pclath, pcl_data, int_req, stk_top,
        output pc, flush, stk_push, stk_pop, stk_in, int_ack, gie_set,
               stk_overflow, stk_underflow
    );

    modport slave (
        output step, op, lit, pclath, pcl_data, int_req, stk_top,
        input  pc, flush, stk_push, stk_pop, stk_in, int_ack, gie_set,
               stk_overflow, stk_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PIC16F program counter / branch / interrupt sequencer
// Optional stack depth checking is enabled by defining STACK_DEPTH_CHECK_EN.
module pc_sequencer #(
    parameter int                     PC_WIDTH     = 13,
    parameter int                     DEPTH_WIDTH  = 3,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 13'h000,
    parameter logic [PC_WIDTH-1:0]    INT_VECTOR   = 13'h004
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [2:0] OP_GOTO   = 3'd1;
    localparam logic [2:0] OP_CALL   = 3'd2;
    localparam logic [2:0] OP_RETURN = 3'd3;
    localparam logic [2:0] OP_RETFIE = 3'd4;
    localparam logic [2:0] OP_SKIP   = 3'd5;
    localparam logic [2:0] OP_PCL    = 3'd6;

    logic [0:0]          state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] op_pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] push_val;
    logic                to_flush;
    logic                push;
    logic                pop;
    logic                ack;
    logic                gie;

    assign pc_inc = pc_q + PC_WIDTH'(1);

    always_comb begin
        op_pc    = pc_inc;
        next_pc  = pc_inc;
        push_val = '0;
        to_flush = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        ack      = 1'b0;
        gie      = 1'b0;
        if (!rst && bus.step && state_q == ST_RUN) begin
            case (bus.op)
                OP_GOTO: begin
                    op_pc    = PC_WIDTH'({bus.pclath[4:3], bus.lit});
                    to_flush = 1'b1;
                end
                OP_CALL: begin
                    op_pc    = PC_WIDTH'({bus.pclath[4:3], bus.lit});
                    push     = 1'b1;
                    push_val = pc_inc;
                    to_flush = 1'b1;
                end
                OP_RETURN: begin
                    op_pc    = bus.stk_top;
                    pop      = 1'b1;
                    to_flush = 1'b1;
                end
                OP_RETFIE: begin
                    op_pc    = bus.stk_top;
                    pop      = 1'b1;
                    gie      = 1'b1;
                    to_flush = 1'b1;
                end
                OP_SKIP:   to_flush = 1'b1;
                OP_PCL: begin
                    op_pc    = PC_WIDTH'({bus.pclath, bus.pcl_data});
                    to_flush = 1'b1;
                end
                default: ;
            endcase
            next_pc = op_pc;
            // Interrupt entry saves where the current op would have gone.
            if (bus.int_req && bus.op != OP_CALL) begin
                push     = 1'b1;
                push_val = op_pc;
                next_pc  = INT_VECTOR;
                ack      = 1'b1;
                to_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            state_q <= ST_RUN;
        end else if (bus.step) begin
            pc_q    <= next_pc;
            state_q <= (state_q == ST_RUN && to_flush) ? ST_FLUSH : ST_RUN;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.flush    = (state_q == ST_FLUSH);
    assign bus.stk_push = push;
    assign bus.stk_pop  = pop;
    assign bus.stk_in   = push_val;
    assign bus.int_ack  = ack;
    assign bus.gie_set  = gie;

`ifdef STACK_DEPTH_CHECK_EN
    localparam logic [DEPTH_WIDTH:0] DEPTH_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};

    logic [DEPTH_WIDTH:0] depth_q;
    logic                 ovf_q;
    logic                 unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (push && !pop) begin
            if (depth_q == DEPTH_MAX) ovf_q <= 1'b1;
            else                      depth_q <= depth_q + 1'b1;
        end else if (pop && !push) begin
            if (depth_q == '0) unf_q <= 1'b1;
            else               depth_q <= depth_q - 1'b1;
        end
    end

    assign bus.stk_overflow  = ovf_q;
    assign bus.stk_underflow = unf_q;
`else
    assign bus.stk_overflow  = |{(DEPTH_WIDTH+1){1'b0}};
    assign bus.stk_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_GOTO   = 3'd1;
    localparam logic [2:0] OP_CALL   = 3'd2;
    localparam logic [2:0] OP_RETURN = 3'd3;
    localparam logic [2:0] OP_RETFIE = 3'd4;
    localparam logic [2:0] OP_SKIP   = 3'd5;
    localparam logic [2:0] OP_PCL    = 3'd6;

`ifdef STACK_DEPTH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [12:0] pc;
        logic        flush;
        logic        push;
        logic        pop;
        logic [12:0] stk_in;
        logic        ack;
        logic        gie;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t obs_q[$];

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [12:0] p, input logic fl, input logic pu,
                                input logic po, input logic [12:0] si, input logic ak,
                                input logic gi);
        exp_t e;
        e.pc = p; e.flush = fl; e.push = pu; e.pop = po;
        e.stk_in = si; e.ack = ak; e.gie = gi;
        return e;
    endfunction

    task automatic do_step(input logic [2:0] o, input logic [10:0] l, input logic [4:0] pl,
                           input logic [7:0] pd, input logic ir, input logic [12:0] top,
                           input exp_t e);
        exp_t ob;
        @(negedge clk);
        bus.step = 1'b1; bus.op = o; bus.lit = l; bus.pclath = pl;
        bus.pcl_data = pd; bus.int_req = ir; bus.stk_top = top;
        exp_q.push_back(e);
        #2;
        ob.flush  = bus.flush;
        ob.push   = bus.stk_push;
        ob.pop    = bus.stk_pop;
        ob.stk_in = bus.stk_push ? bus.stk_in : 13'h0;
        ob.ack    = bus.int_ack;
        ob.gie    = bus.gie_set;
        @(posedge clk);
        #1;
        ob.pc = bus.pc;
        obs_q.push_back(ob);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; bus.step = 1'b0; bus.int_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst = 1'b1;
        do_step(OP_CALL, 11'h7FF, 5'h1F, 8'hFF, 1'b1, 13'h1234, mk(13'h000, 0, 0, 0, 13'h0, 0, 0));
        do_step(OP_RETFIE, 11'h0, 5'h0, 8'h0, 1'b1, 13'h0555, mk(13'h000, 0, 0, 0, 13'h0, 0, 0));
        n_cmp++;
        if (bus.stk_overflow !== 1'b0 || bus.stk_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", bus.stk_overflow, bus.stk_underflow);
        end
        @(negedge clk);
        rst = 1'b0; bus.step = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset: got %h want %h (pc,flush,push,pop,stk_in,ack,gie)", o, e);
            end
        end
    endtask

    task automatic test_sequential();
        exp_t e, o;
        for (int i = 1; i <= 3; i++)
            do_step(OP_NONE, 11'h0, 5'h0, 8'h0, 1'b0, 13'h0, mk(13'(i), 0, 0, 0, 13'h0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL sequential: got %h want %h (pc,flush,push,pop,stk_in,ack,gie)", o, e);
            end
        end
    endtask

    task automatic test_call_return();
        exp_t e, o;
        do_step(OP_GOTO,   11'h00F, 5'h00, 8'h0, 1'b0, 13'h0,   mk(13'h00F,  0, 0, 0, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h00, 8'h0, 1'b0, 13'h0,   mk(13'h010,  1, 0, 0, 13'h0,   0, 0));
        do_step(OP_CALL,   11'h123, 5'h18, 8'h0, 1'b0, 13'h0,   mk(13'h1923, 0, 1, 0, 13'h011, 0, 0));
        do_step(OP_NONE,   11'h0,   5'h18, 8'h0, 1'b1, 13'h0,   mk(13'h1924, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_RETURN, 11'h0,   5'h00, 8'h0, 1'b0, 13'h011, mk(13'h011,  0, 0, 1, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h00, 8'h0, 1'b0, 13'h0,   mk(13'h012,  1, 0, 0, 13'h0,   0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL call_return: got %h want %h (pc,flush,push,pop,stk_in,ack,gie)", o, e);
            end
        end
    endtask

    task automatic test_pcl_skip();
        exp_t e, o;
        do_step(OP_PCL,  11'h0,   5'h02, 8'h40, 1'b0, 13'h0, mk(13'h0240, 0, 0, 0, 13'h0, 0, 0));
        do_step(OP_NONE, 11'h0,   5'h02, 8'h00, 1'b0, 13'h0, mk(13'h0241, 1, 0, 0, 13'h0, 0, 0));
        do_step(OP_GOTO, 11'h004, 5'h00, 8'h00, 1'b0, 13'h0, mk(13'h004,  0, 0, 0, 13'h0, 0, 0));
        do_step(OP_NONE, 11'h0,   5'h00, 8'h00, 1'b0, 13'h0, mk(13'h005,  1, 0, 0, 13'h0, 0, 0));
        do_step(OP_SKIP, 11'h0,   5'h00, 8'h00, 1'b0, 13'h0, mk(13'h006,  0, 0, 0, 13'h0, 0, 0));
        do_step(OP_NONE, 11'h0,   5'h00, 8'h00, 1'b0, 13'h0, mk(13'h007,  1, 0, 0, 13'h0, 0, 0));
        do_step(3'd7,    11'h0,   5'h00, 8'h00, 1'b0, 13'h0, mk(13'h008,  0, 0, 0, 13'h0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pcl_skip: got %h want %h (pc,flush,push,pop,stk_in,ack,gie)", o, e);
            end
        end
    endtask

    task automatic test_interrupt();
        exp_t e, o;
        do_step(OP_GOTO,   11'h01F, 5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h01F, 0, 0, 0, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h020, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b1, 13'h0,   mk(13'h004, 0, 1, 0, 13'h021, 1, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b1, 13'h0,   mk(13'h005, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_CALL,   11'h100, 5'h0, 8'h0, 1'b1, 13'h0,   mk(13'h100, 0, 1, 0, 13'h006, 0, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b1, 13'h0,   mk(13'h101, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b1, 13'h0,   mk(13'h004, 0, 1, 0, 13'h102, 1, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h005, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_RETFIE, 11'h0,   5'h0, 8'h0, 1'b0, 13'h102, mk(13'h102, 0, 0, 1, 13'h0,   0, 1));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h103, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_RETFIE, 11'h0,   5'h0, 8'h0, 1'b1, 13'h0AA, mk(13'h004, 0, 1, 1, 13'h0AA, 1, 1));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h005, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_RETURN, 11'h0,   5'h0, 8'h0, 1'b0, 13'h006, mk(13'h006, 0, 0, 1, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h007, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_RETURN, 11'h0,   5'h0, 8'h0, 1'b0, 13'h021, mk(13'h021, 0, 0, 1, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h022, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_GOTO,   11'h050, 5'h0, 8'h0, 1'b1, 13'h0,   mk(13'h004, 0, 1, 0, 13'h050, 1, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h005, 1, 0, 0, 13'h0,   0, 0));
        do_step(OP_RETURN, 11'h0,   5'h0, 8'h0, 1'b0, 13'h050, mk(13'h050, 0, 0, 1, 13'h0,   0, 0));
        do_step(OP_NONE,   11'h0,   5'h0, 8'h0, 1'b0, 13'h0,   mk(13'h051, 1, 0, 0, 13'h0,   0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL interrupt: got %h want %h (pc,flush,push,pop,stk_in,ack,gie)", o, e);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e, o;
        do_step(OP_GOTO, 11'h7FE, 5'h18, 8'h0, 1'b0, 13'h0, mk(13'h1FFE, 0, 0, 0, 13'h0, 0, 0));
        do_step(OP_NONE, 11'h0,   5'h00, 8'h0, 1'b0, 13'h0, mk(13'h1FFF, 1, 0, 0, 13'h0, 0, 0));
        do_step(OP_NONE, 11'h0,   5'h00, 8'h0, 1'b0, 13'h0, mk(13'h0000, 0, 0, 0, 13'h0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL wrap: got %h want %h (pc,flush,push,pop,stk_in,ack,gie)", o, e);
            end
        end
    endtask

    task automatic test_idle();
        logic [3:0] strobes;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.step = 1'b0; bus.op = (i == 0) ? OP_CALL : OP_RETFIE;
            bus.int_req = 1'b1; bus.lit = 11'h3AB;
            #2;
            strobes = {bus.stk_push, bus.stk_pop, bus.int_ack, bus.gie_set};
            n_cmp++;
            if (strobes !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_strobes[%0d]: got %b want 0000", i, strobes);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.pc !== 13'h0000 || bus.flush !== 1'b0) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got pc=%h flush=%b want 0000 0", i, bus.pc, bus.flush);
            end
        end
    endtask

    task automatic test_stack_depth();
        exp_t e, o;
        apply_reset();
        for (int k = 1; k <= 9; k++) begin
            do_step(OP_CALL, 11'h200, 5'h0, 8'h0, 1'b0, 13'h0,
                    mk(13'h200, 0, 1, 0, (k == 1) ? 13'h001 : 13'h202, 0, 0));
            n_cmp++;
            if (bus.stk_overflow !== (CHK && k == 9)) begin
                n_err++;
                $display("FAIL overflow_call%0d: got %b want %b", k, bus.stk_overflow, CHK && k == 9);
            end
            do_step(OP_NONE, 11'h0, 5'h0, 8'h0, 1'b0, 13'h0, mk(13'h201, 1, 0, 0, 13'h0, 0, 0));
        end
        apply_reset();
        n_cmp++;
        if (bus.stk_overflow !== 1'b0 || bus.pc !== 13'h000) begin
            n_err++;
            $display("FAIL overflow_cleared: got ovf=%b pc=%h want 0 000", bus.stk_overflow, bus.pc);
        end
        do_step(OP_RETURN, 11'h0, 5'h0, 8'h0, 1'b0, 13'h333, mk(13'h333, 0, 0, 1, 13'h0, 0, 0));
        n_cmp++;
        if (bus.stk_underflow !== CHK) begin
            n_err++;
            $display("FAIL underflow: got %b want %b", bus.stk_underflow, CHK);
        end
        do_step(OP_NONE, 11'h0, 5'h0, 8'h0, 1'b0, 13'h0, mk(13'h334, 1, 0, 0, 13'h0, 0, 0));
        n_cmp++;
        if (bus.stk_underflow !== CHK) begin
            n_err++;
            $display("FAIL underflow_sticky: got %b want %b", bus.stk_underflow, CHK);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL stack_depth: got %h want %h (pc,flush,push,pop,stk_in,ack,gie)", o, e);
            end
        end
    endtask

    initial begin
        bus.step = 1'b0; bus.op = OP_NONE; bus.lit = '0; bus.pclath = '0;
        bus.pcl_data = '0; bus.int_req = 1'b0; bus.stk_top = '0;
        test_reset();
        test_sequential();
        test_call_return();
        test_pcl_skip();
        test_interrupt();
        test_wrap();
        test_idle();
        test_stack_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
